// File: rtl/gpu_wb_pkg.sv
// Shared constants and types for the register-file write-back stage.
// Source encodings identify which producer owns the write port in a given cycle.
package gpu_wb_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_ALU  = 2'd1;
  localparam logic [1:0] SRC_LD   = 2'd2;
  localparam logic [1:0] SRC_DIV  = 2'd3;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
  } wb_rec_t;

endpackage

// File: rtl/gpu_wb_fifo.sv
// Small synchronous FIFO with asynchronous active-high reset.
// Push when full is ignored unless a pop happens the same cycle; pop when empty is ignored.
module gpu_wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gpu_wback.sv
// Register-file write-back: merges ALU, load-return and divide results onto one
// registered write port with fixed priority, and tracks pending load/divide targets.
module gpu_wback #(
  parameter int DW        = gpu_wb_pkg::DW,
  parameter int AW        = gpu_wb_pkg::AW,
  parameter int LDQ_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_wr,
  input  logic [AW-1:0]    alu_dst,
  input  logic [DW-1:0]    alu_data,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_issue_dst,
  input  logic             ld_wr,
  input  logic [AW-1:0]    ld_dst,
  input  logic [DW-1:0]    ld_data,
  output logic             ld_ready,
  input  logic             div_issue,
  input  logic [AW-1:0]    div_issue_dst,
  input  logic             div_wr,
  input  logic [AW-1:0]    div_dst,
  input  logic [DW-1:0]    div_data,
  output logic             div_ready,
  output logic             rf_we,
  output logic [AW-1:0]    rf_addr,
  output logic [DW-1:0]    rf_data,
  output logic [2**AW-1:0] reg_pending,
  output logic             err_ovf
);

  import gpu_wb_pkg::*;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+DW-1:0] fifo_rdata;

  logic             hold_vld;
  logic [AW-1:0]    hold_dst;
  logic [DW-1:0]    hold_data;
  logic             hold_set;
  logic             hold_clr;

  logic             ld_acc;
  logic             div_acc;
  logic             ld_cand;
  logic             div_cand;
  logic [AW-1:0]    ld_cand_dst;
  logic [DW-1:0]    ld_cand_data;
  logic [AW-1:0]    div_cand_dst;
  logic [DW-1:0]    div_cand_data;

  logic [1:0]       win_src;
  logic [AW-1:0]    win_dst;
  logic [DW-1:0]    win_data;
  logic [2**AW-1:0] pend_nxt;
  logic             ovf_now;

  gpu_wb_fifo #(
    .W     (AW + DW),
    .DEPTH (LDQ_DEPTH)
  ) u_ldq (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({ld_dst, ld_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    // A full FIFO is never empty, so its head drains exactly when the ALU is idle.
    ld_ready  = ~fifo_full | ~alu_wr;
    div_ready = ~hold_vld;
    ld_acc    = ld_wr & ld_ready;
    div_acc   = div_wr & div_ready;
    ovf_now   = (ld_wr & ~ld_ready) | (div_wr & ~div_ready);

    ld_cand       = ~fifo_empty | ld_acc;
    ld_cand_dst   = fifo_empty ? ld_dst  : fifo_rdata[AW+DW-1:DW];
    ld_cand_data  = fifo_empty ? ld_data : fifo_rdata[DW-1:0];
    div_cand      = hold_vld | div_acc;
    div_cand_dst  = hold_vld ? hold_dst  : div_dst;
    div_cand_data = hold_vld ? hold_data : div_data;

    win_src  = SRC_NONE;
    win_dst  = '0;
    win_data = '0;
    if (alu_wr) begin
      win_src  = SRC_ALU;
      win_dst  = alu_dst;
      win_data = alu_data;
    end else if (ld_cand) begin
      win_src  = SRC_LD;
      win_dst  = ld_cand_dst;
      win_data = ld_cand_data;
    end else if (div_cand) begin
      win_src  = SRC_DIV;
      win_dst  = div_cand_dst;
      win_data = div_cand_data;
    end

    fifo_pop  = (win_src == SRC_LD) & ~fifo_empty;
    fifo_push = ld_acc & ~((win_src == SRC_LD) & fifo_empty);
    hold_set  = div_acc & (win_src != SRC_DIV);
    hold_clr  = (win_src == SRC_DIV) & hold_vld;

    // Clear first so a same-cycle issue to the retiring index keeps it pending.
    pend_nxt = reg_pending;
    if (win_src == SRC_LD || win_src == SRC_DIV) pend_nxt[win_dst] = 1'b0;
    if (ld_issue)  pend_nxt[ld_issue_dst]  = 1'b1;
    if (div_issue) pend_nxt[div_issue_dst] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_vld  <= 1'b0;
      hold_dst  <= '0;
      hold_data <= '0;
    end else if (hold_set) begin
      hold_vld  <= 1'b1;
      hold_dst  <= div_dst;
      hold_data <= div_data;
    end else if (hold_clr) begin
      hold_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_data     <= '0;
      reg_pending <= '0;
      err_ovf     <= 1'b0;
    end else begin
      rf_we       <= (win_src != SRC_NONE);
      reg_pending <= pend_nxt;
      if (ovf_now) err_ovf <= 1'b1;
      if (win_src != SRC_NONE) begin
        rf_addr <= win_dst;
        rf_data <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_gpu_wback.sv
// Bench for gpu_wback: directed scenarios plus random traffic against a queue-based model.
module tb_gpu_wback;
  import gpu_wb_pkg::*;

  localparam int LDQ_DEPTH = 2;
  localparam int NREG      = 2**AW;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_wr;
  logic [AW-1:0]   alu_dst;
  logic [DW-1:0]   alu_data;
  logic            ld_issue;
  logic [AW-1:0]   ld_issue_dst;
  logic            ld_wr;
  logic [AW-1:0]   ld_dst;
  logic [DW-1:0]   ld_data;
  logic            ld_ready;
  logic            div_issue;
  logic [AW-1:0]   div_issue_dst;
  logic            div_wr;
  logic [AW-1:0]   div_dst;
  logic [DW-1:0]   div_data;
  logic            div_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_data;
  logic [NREG-1:0] reg_pending;
  logic            err_ovf;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: queues of waiting results and the expected port state.
  wb_rec_t         ldq[$];
  wb_rec_t         divq[$];
  logic [NREG-1:0] m_pend;
  logic            m_err;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;

  gpu_wback #(.DW(DW), .AW(AW), .LDQ_DEPTH(LDQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_wr(alu_wr), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst),
    .ld_wr(ld_wr), .ld_dst(ld_dst), .ld_data(ld_data), .ld_ready(ld_ready),
    .div_issue(div_issue), .div_issue_dst(div_issue_dst),
    .div_wr(div_wr), .div_dst(div_dst), .div_data(div_data), .div_ready(div_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .reg_pending(reg_pending), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_wr = 0; alu_dst = '0; alu_data = '0;
    ld_issue = 0; ld_issue_dst = '0;
    ld_wr = 0; ld_dst = '0; ld_data = '0;
    div_issue = 0; div_issue_dst = '0;
    div_wr = 0; div_dst = '0; div_data = '0;
  endtask

  task automatic model_clear();
    ldq.delete();
    divq.delete();
    m_pend = '0; m_err = 0; m_we = 0; m_addr = '0; m_data = '0;
  endtask

  // A load fits if the queue has space once this cycle's departure (if any) has left.
  function automatic bit model_ld_room();
    int drain;
    drain = (!alu_wr && ldq.size() > 0) ? 1 : 0;
    return (ldq.size() - drain) < LDQ_DEPTH;
  endfunction

  task automatic model_step();
    wb_rec_t r;
    bit room;
    room = model_ld_room();
    if (ld_wr) begin
      if (room) ldq.push_back('{dst: ld_dst, data: ld_data});
      else m_err = 1;
    end
    if (div_wr) begin
      if (divq.size() == 0) divq.push_back('{dst: div_dst, data: div_data});
      else m_err = 1;
    end
    m_we = 0;
    if (alu_wr) begin
      m_we = 1; m_addr = alu_dst; m_data = alu_data;
    end else if (ldq.size() > 0) begin
      r = ldq.pop_front();
      m_we = 1; m_addr = r.dst; m_data = r.data; m_pend[r.dst] = 0;
    end else if (divq.size() > 0) begin
      r = divq.pop_front();
      m_we = 1; m_addr = r.dst; m_data = r.data; m_pend[r.dst] = 0;
    end
    if (ld_issue)  m_pend[ld_issue_dst]  = 1;
    if (div_issue) m_pend[div_issue_dst] = 1;
  endtask

  task automatic check_regs();
    check("rf_we", rf_we, m_we);
    check("rf_addr", rf_addr, m_addr);
    check("rf_data", rf_data, m_data);
    check("reg_pending", reg_pending, m_pend);
    check("err_ovf", err_ovf, m_err);
  endtask

  // Called just after a falling edge with this cycle's inputs already applied.
  task automatic tick();
    #1;
    check("ld_ready", ld_ready, model_ld_room());
    check("div_ready", div_ready, divq.size() == 0);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1;
    #1;
    idle_inputs();
    model_clear();
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_pending", reg_pending, '0);
    check("rst_err", err_ovf, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_div_ready", div_ready, 1'b1);
    @(negedge clk);
    check("rst_held_we", rf_we, 1'b0);
    reset = 0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    check_regs();
    check("init_ld_ready", ld_ready, 1'b1);
    check("init_div_ready", div_ready, 1'b1);

    // ALU only
    alu_wr = 1; alu_dst = 5'd3; alu_data = 32'h1234_5678;
    tick();
    check("alu_addr", rf_addr, 5'd3);
    check("alu_data", rf_data, 32'h1234_5678);
    idle_inputs();
    tick();

    // Load bypass with scoreboard clear
    ld_issue = 1; ld_issue_dst = 5'd7;
    tick();
    check("ld_pend_set", reg_pending[7], 1'b1);
    idle_inputs();
    tick();
    ld_wr = 1; ld_dst = 5'd7; ld_data = 32'hDEAD_BEEF;
    tick();
    check("bypass_we", rf_we, 1'b1);
    check("bypass_pend_clr", reg_pending[7], 1'b0);
    idle_inputs();

    // Three-way collision: r1, r2, r4 on consecutive cycles
    alu_wr = 1; alu_dst = 5'd1; alu_data = 32'h1111;
    ld_wr = 1; ld_dst = 5'd2; ld_data = 32'h2222;
    div_wr = 1; div_dst = 5'd4; div_data = 32'h4444;
    tick();
    idle_inputs();
    check("coll_div_ready0", div_ready, 1'b0);
    tick();
    check("coll_r2", rf_addr, 5'd2);
    check("coll_div_ready1", div_ready, 1'b0);
    tick();
    check("coll_r4", rf_addr, 5'd4);
    check("coll_div_free", div_ready, 1'b1);

    // FIFO full under sustained ALU traffic, third load dropped
    for (int i = 0; i < 4; i++) begin
      alu_wr = 1; alu_dst = 5'(20 + i); alu_data = 32'(32'hA0 + i);
      ld_wr = (i < 3); ld_dst = 5'(12 + i); ld_data = 32'(32'hB0 + i);
      tick();
    end
    check("full_err", err_ovf, 1'b1);
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    pulse_reset();

    // Scoreboard race on r9
    ld_issue = 1; ld_issue_dst = 5'd9;
    tick();
    ld_wr = 1; ld_dst = 5'd9; ld_data = 32'h9999;
    tick();
    check("race_pend9", reg_pending[9], 1'b1);
    idle_inputs();
    tick();

    // Async reset with two queued loads and a held divide
    div_issue = 1; div_issue_dst = 5'd11;
    alu_wr = 1; alu_dst = 5'd5; alu_data = 32'h55;
    ld_wr = 1; ld_dst = 5'd10; ld_data = 32'hA;
    div_wr = 1; div_dst = 5'd11; div_data = 32'hB;
    tick();
    div_issue = 0; div_wr = 0;
    ld_dst = 5'd12; ld_data = 32'hC;
    tick();
    check("pre_rst_we", rf_we, 1'b1);
    pulse_reset();
    for (int i = 0; i < 4; i++) tick();

    // Random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      alu_wr = ($urandom_range(0, 9) < 4);
      alu_dst = 5'($urandom); alu_data = $urandom;
      ld_issue = ($urandom_range(0, 9) < 2); ld_issue_dst = 5'($urandom);
      ld_wr = ($urandom_range(0, 9) < 3);
      ld_dst = 5'($urandom); ld_data = $urandom;
      div_issue = ($urandom_range(0, 9) < 1); div_issue_dst = 5'($urandom);
      div_wr = ($urandom_range(0, 19) < 3);
      div_dst = 5'($urandom); div_data = $urandom;
      tick();
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
